// File: rtl/seg7_scan_driver.sv
// Multi-digit hex 7-segment scan driver: latches DIGITS nibbles, scans them onto a shared bus.
// Latency: input latched on edge n, shown on seg at edge n+1 when its digit is selected.
// Backpressure: none; le=1 freezes the latch, the scan itself never stalls.
//
// Ports:
//   clk, rst           rising-edge clock, asynchronous active-high reset
//   hex_in             DIGITS packed nibbles, digit 0 in bits [3:0] (rightmost)
//   point_in/blank_in  per-digit decimal point request / full blank
//   le                 latch enable (0 = capture every edge, 1 = hold)
//   lz_en              leading-zero suppression enable
//   seg                registered {p,g,f,e,d,c,b,a}
//   an                 registered one-hot digit select
// ACTIVE_LOW inverts seg and an at the output registers.
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] hex_in,
  input  logic [DIGITS-1:0]   point_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                le,
  input  logic                lz_en,
  output logic [7:0]          seg,
  output logic [DIGITS-1:0]   an
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0]     CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  // XOR masks applied at the output registers; also the "all inactive" value.
  localparam logic [7:0]        SEG_OFF  = {8{ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};

  logic [4*DIGITS-1:0] hex_q;
  logic [DIGITS-1:0]   pnt_q;
  logic [DIGITS-1:0]   blk_q;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [DIGITS-1:0]   sup;
  logic [7:0]          seg_raw;
  logic [DIGITS-1:0]   an_raw;

  // Active-high {g..a} for one nibble.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

  // Stage 1: input latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_q <= '0;
      pnt_q <= '0;
      blk_q <= '0;
    end else if (!le) begin
      hex_q <= hex_in;
      pnt_q <= point_in;
      blk_q <= blank_in;
    end
  end

  // Stage 1: prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Leading-zero mask: walk from the leftmost digit down, a digit is
  // suppressed while every nibble from it upward is still zero.
  // Digit 0 is always shown so an all-zero value reads "0".
  always_comb begin
    logic zrun;
    zrun = 1'b1;
    sup  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zrun = zrun & (hex_q[4*i +: 4] == 4'h0);
      if (i > 0) sup[i] = zrun & lz_en;
    end
  end

  // Active-high segment/anode for the currently selected digit.
  always_comb begin
    seg_raw = 8'h00;
    an_raw  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        an_raw[i] = 1'b1;
        // Blank overrides both the decode and the point.
        if (!blk_q[i])
          seg_raw = {pnt_q[i], sup[i] ? 7'h00 : hex7(hex_q[4*i +: 4])};
      end
    end
  end

  // Stage 2: registered outputs keep seg/an glitch-free between edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_raw ^ SEG_OFF;
      an  <= an_raw ^ AN_OFF;
    end
  end

endmodule
